rec2pol_scheduler: RTL and testbench

- Shares one rec2pol_wind CORDIC core (rectangular to polar: x,y to mod,angle) between NREQ wind-sensor channel requesters.
- Round-robin arbitration, operand capture, core start sequencing, fixed-latency result capture, and result tagging with channel id.
- Sits between the per-axis sensor processing channels and the single shared CORDIC instance. The core has no done flag, so completion is timed by a counter.

---
 rtl/rec2pol_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_rec2pol_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec2pol_scheduler.sv
// -----------------------------------------------------------------------------
// rec2pol_scheduler
//
// Shares a single rec2pol_wind CORDIC core (x,y -> modulus,angle) between
// NREQ wind-sensor channels. A round-robin arbiter picks a requester. Its
// operands are latched onto the core inputs, and the core is started with a
// one-cycle pulse. The core has no done flag, so a down-counter waits a fixed
// LATENCY before the modulus and angle are captured. The result is then
// presented with the owning channel id.
//
// Optional build macro: R2P_ZERO_BYPASS_EN
//   When defined, a granted (0,0) operand pair is not sent to the core. The
//   result (0,0) is produced the cycle after ack instead.
//
// Parameters:
//   NREQ     number of requesters (2..4)
//   IDW      channel id width, 2**IDW >= NREQ
//   LATENCY  cycles from the core sampling start to its outputs being stable
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   req           per-channel level request, held with stable operands until ack
//   x_in, y_in    packed signed operands, channel i at [16i+15:16i]
//   ack           one-hot one-cycle pulse: the channel's operands are captured
//   cordic_start  one-cycle start pulse to the core
//   cordic_x/y    operands to the core, stable from ack until the next grant
//   cordic_mod    core modulus result
//   cordic_angle  core angle result
//   res_valid     one-cycle pulse: res_id/res_mod/res_angle are valid
//   res_id        channel that owns the result
//   res_mod       captured modulus
//   res_angle     captured angle
//   busy          high while not IDLE
// -----------------------------------------------------------------------------
module rec2pol_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   x_in,
  input  logic [NREQ*16-1:0]   y_in,
  output logic [NREQ-1:0]      ack,
  output logic                 cordic_start,
  output logic [15:0]          cordic_x,
  output logic [15:0]          cordic_y,
  input  logic [15:0]          cordic_mod,
  input  logic [15:0]          cordic_angle,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [15:0]          res_mod,
  output logic [15:0]          res_angle,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    ptr, ptr_n;
  logic [IDW-1:0]    gnt, gnt_n;
  logic [7:0]        cnt, cnt_n;
  logic [NREQ-1:0]   ack_n;
  logic              start_n;
  logic [15:0]       x_n, y_n;
  logic              rv_n;
  logic [IDW-1:0]    rid_n;
  logic [15:0]       rmod_n, rang_n;
  logic              busy_n;

  logic              found;
  logic [IDW-1:0]    gsel;
  logic [NREQ-1:0]   gonehot;
  logic [15:0]       sel_x, sel_y;
  logic [IDW-1:0]    ptr_after;

`ifdef R2P_ZERO_BYPASS_EN
  logic              bypass, bypass_n;
  logic              zero_ops;
`endif

  // Round-robin search. Channels at or above the pointer are scanned first,
  // then the ones below it, which gives the wrap-around order without
  // computed indices.
  always_comb begin
    found   = 1'b0;
    gsel    = '0;
    gonehot = '0;
    sel_x   = '0;
    sel_y   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found      = 1'b1;
        gsel       = IDW'(i);
        gonehot    = '0;
        gonehot[i] = 1'b1;
        sel_x      = x_in[16*i +: 16];
        sel_y      = y_in[16*i +: 16];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found      = 1'b1;
        gsel       = IDW'(i);
        gonehot    = '0;
        gonehot[i] = 1'b1;
        sel_x      = x_in[16*i +: 16];
        sel_y      = y_in[16*i +: 16];
      end
    end
  end

  // The pointer moves one past the channel that was just served.
  always_comb begin
    if (gnt == IDW'(NREQ - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = gnt + IDW'(1);
    end
  end

`ifdef R2P_ZERO_BYPASS_EN
  assign zero_ops = (sel_x == 16'd0) && (sel_y == 16'd0);
`endif

  // Next-state and next-output logic. Every output is a register, so this
  // block computes the value that each one takes at the next edge.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    cnt_n   = cnt;
    ack_n   = '0;
    start_n = 1'b0;
    x_n     = cordic_x;
    y_n     = cordic_y;
    rv_n    = 1'b0;
    rid_n   = res_id;
    rmod_n  = res_mod;
    rang_n  = res_angle;
`ifdef R2P_ZERO_BYPASS_EN
    bypass_n = bypass;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = gsel;
          x_n     = sel_x;
          y_n     = sel_y;
          ack_n   = gonehot;
          state_n = ISSUE;
`ifdef R2P_ZERO_BYPASS_EN
          start_n  = !zero_ops;
          bypass_n = zero_ops;
`else
          start_n = 1'b1;
`endif
        end
      end
      ISSUE: begin
`ifdef R2P_ZERO_BYPASS_EN
        // A zero operand pair never reaches the core. The ack cycle is
        // followed directly by a (0,0) result.
        if (bypass) begin
          rv_n    = 1'b1;
          rid_n   = gnt;
          rmod_n  = '0;
          rang_n  = '0;
          ptr_n   = ptr_after;
          state_n = IDLE;
        end else begin
          cnt_n   = 8'(LATENCY - 1);
          state_n = WAIT;
        end
`else
        cnt_n   = 8'(LATENCY - 1);
        state_n = WAIT;
`endif
      end
      WAIT: begin
        // The count reaches zero on the edge that lies LATENCY cycles after
        // the core sampled start. That is when its outputs are stable.
        if (cnt == 8'd0) begin
          rmod_n  = cordic_mod;
          rang_n  = cordic_angle;
          rv_n    = 1'b1;
          rid_n   = gnt;
          ptr_n   = ptr_after;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs. Reset discards any conversion in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      cnt          <= '0;
      ack          <= '0;
      cordic_start <= 1'b0;
      cordic_x     <= '0;
      cordic_y     <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_mod      <= '0;
      res_angle    <= '0;
      busy         <= 1'b0;
`ifdef R2P_ZERO_BYPASS_EN
      bypass       <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      gnt          <= gnt_n;
      cnt          <= cnt_n;
      ack          <= ack_n;
      cordic_start <= start_n;
      cordic_x     <= x_n;
      cordic_y     <= y_n;
      res_valid    <= rv_n;
      res_id       <= rid_n;
      res_mod      <= rmod_n;
      res_angle    <= rang_n;
      busy         <= busy_n;
`ifdef R2P_ZERO_BYPASS_EN
      bypass       <= bypass_n;
`endif
    end
  end

endmodule

// File: tb/tb_rec2pol_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rec2pol_scheduler
//
// Directed bench for rec2pol_scheduler with NREQ=4, IDW=2, LATENCY=16.
// A small behavioural CORDIC stand-in latches operands on start. It shows a
// garbage value until LATENCY cycles have elapsed. After that it shows
// mod = x ^ 16'h5A5A and angle = y + 16'h0013. Capturing too early therefore
// shows up as 16'hDEAD.
// -----------------------------------------------------------------------------
module tb_rec2pol_scheduler;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*16-1:0]  x_in;
  logic [NREQ*16-1:0]  y_in;
  logic [NREQ-1:0]     ack;
  logic                cordic_start;
  logic [15:0]         cordic_x;
  logic [15:0]         cordic_y;
  logic [15:0]         cordic_mod;
  logic [15:0]         cordic_angle;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [15:0]         res_mod;
  logic [15:0]         res_angle;
  logic                busy;

  int errorCount = 0;
  int checkCount = 0;
  int tbCycle    = 0;
  int resCount   = 0;
  int res3Count  = 0;
  int ack3Count  = 0;

  rec2pol_scheduler #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .x_in         (x_in),
    .y_in         (y_in),
    .ack          (ack),
    .cordic_start (cordic_start),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_mod   (cordic_mod),
    .cordic_angle (cordic_angle),
    .res_valid    (res_valid),
    .res_id       (res_id),
    .res_mod      (res_mod),
    .res_angle    (res_angle),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Behavioural core: a fixed latency and no done flag.
  logic [15:0] coreX = '0;
  logic [15:0] coreY = '0;
  int          coreAge = 0;
  logic        coreLive = 1'b0;

  always @(posedge clock) begin
    if (cordic_start) begin
      coreX    <= cordic_x;
      coreY    <= cordic_y;
      coreAge  <= 0;
      coreLive <= 1'b1;
    end else if (coreLive && coreAge < 1000) begin
      coreAge <= coreAge + 1;
    end
  end

  assign cordic_mod   = (coreLive && coreAge >= LATENCY - 1) ? (coreX ^ 16'h5A5A)   : 16'hDEAD;
  assign cordic_angle = (coreLive && coreAge >= LATENCY - 1) ? (coreY + 16'h0013)   : 16'hDEAD;

  // Event counters that are read back by the directed sequence.
  always @(negedge clock) begin
    if (res_valid) resCount = resCount + 1;
    if (res_valid && res_id == 2'd3) res3Count = res3Count + 1;
    if (ack[3]) ack3Count = ack3Count + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    tbCycle++;
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b0;
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  task automatic setOperand(input int ch, input logic [15:0] x, input logic [15:0] y);
    x_in[16*ch +: 16] = x;
    y_in[16*ch +: 16] = y;
  endtask

  task automatic waitAck(output bit got);
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (ack != '0) got = 1'b1;
    end
  endtask

  // Serves one conversion. It waits for ack, checks the issue-side outputs,
  // counts cycles to res_valid and checks the tagged result. It returns in
  // the res_valid cycle.
  task automatic applyStimulus(input int ch, input logic [15:0] ex, input logic [15:0] ey,
                               input int expLat, input bit expStart, input bit dropReq,
                               output int ackAt);
    bit got;
    int n;
    logic [15:0] expMod, expAng;
    ackAt = tbCycle;
    waitAck(got);
    if (!got) begin
      checkOutput($sformatf("ack timeout ch%0d", ch), 64'd0, 64'd1);
      return;
    end
    ackAt = tbCycle;
    checkOutput($sformatf("ack ch%0d", ch), 64'(ack), 64'(1) << ch);
    checkOutput($sformatf("start ch%0d", ch), 64'(cordic_start), 64'(expStart));
    checkOutput($sformatf("cordic_x ch%0d", ch), 64'(cordic_x), 64'(ex));
    checkOutput($sformatf("cordic_y ch%0d", ch), 64'(cordic_y), 64'(ey));
    checkOutput($sformatf("busy ch%0d", ch), 64'(busy), 64'd1);
    if (dropReq) req[ch] = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        checkOutput($sformatf("ack pulse ch%0d", ch), 64'(ack), 64'd0);
        checkOutput($sformatf("start pulse ch%0d", ch), 64'(cordic_start), 64'd0);
      end
      if (res_valid) got = 1'b1;
    end
    expMod = expStart ? (ex ^ 16'h5A5A) : 16'h0000;
    expAng = expStart ? (ey + 16'h0013) : 16'h0000;
    checkOutput($sformatf("latency ch%0d", ch), 64'(n), 64'(expLat));
    checkOutput($sformatf("res_id ch%0d", ch), 64'(res_id), 64'(ch));
    checkOutput($sformatf("res_mod ch%0d", ch), 64'(res_mod), 64'(expMod));
    checkOutput($sformatf("res_angle ch%0d", ch), 64'(res_angle), 64'(expAng));
    checkOutput($sformatf("operand hold ch%0d", ch), 64'({cordic_x, cordic_y}), 64'({ex, ey}));
  endtask

  initial begin
    int a0, a1, a2, a3, a4;
    int base, base3, baseAck3;
    bit got;

    reset = 1'b0;
    req   = '0;
    x_in  = '0;
    y_in  = '0;
    $display("[TB] start");

    // Reset state and a quiet idle period.
    applyReset(3);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle ctrl", 64'({ack, cordic_start, res_valid, res_id, busy}), 64'd0);
      checkOutput("idle data", 64'({cordic_x, cordic_y, res_mod, res_angle}), 64'd0);
    end

    // Single request on channel 0.
    setOperand(0, 16'd1000, 16'd0);
    req[0] = 1'b1;
    applyStimulus(0, 16'd1000, 16'd0, LATENCY + 1, 1'b1, 1'b1, a0);

    // All four channels request continuously: order 0,1,2,3,0 and 18-cycle spacing.
    applyReset(2);
    setOperand(0, 16'd1600, 16'd1600);
    setOperand(1, 16'd0,    16'd5000);
    setOperand(2, 16'd8050, 16'hF800);
    setOperand(3, 16'd1024, 16'hF830);
    base = resCount;
    req = 4'b1111;
    applyStimulus(0, 16'd1600, 16'd1600, LATENCY + 1, 1'b1, 1'b0, a0);
    applyStimulus(1, 16'd0,    16'd5000, LATENCY + 1, 1'b1, 1'b0, a1);
    applyStimulus(2, 16'd8050, 16'hF800, LATENCY + 1, 1'b1, 1'b0, a2);
    applyStimulus(3, 16'd1024, 16'hF830, LATENCY + 1, 1'b1, 1'b0, a3);
    applyStimulus(0, 16'd1600, 16'd1600, LATENCY + 1, 1'b1, 1'b0, a4);
    req = '0;
    checkOutput("spacing 0-1", 64'(a1 - a0), 64'(LATENCY + 2));
    checkOutput("spacing 1-2", 64'(a2 - a1), 64'(LATENCY + 2));
    checkOutput("spacing 2-3", 64'(a3 - a2), 64'(LATENCY + 2));
    checkOutput("spacing 3-0", 64'(a4 - a3), 64'(LATENCY + 2));
    tick();
    checkOutput("rr result count", 64'(resCount - base), 64'd5);

    // Pointer is at 1. Channel 2 is granted first, then channel 0 wins over 2 by wrap.
    req = 4'b0101;
    applyStimulus(2, 16'd8050, 16'hF800, LATENCY + 1, 1'b1, 1'b0, a0);
    applyStimulus(0, 16'd1600, 16'd1600, LATENCY + 1, 1'b1, 1'b1, a1);
    applyStimulus(2, 16'd8050, 16'hF800, LATENCY + 1, 1'b1, 1'b1, a2);

    // One-cycle pulse on req[3] while busy must be ignored.
    baseAck3 = ack3Count;
    base3    = res3Count;
    setOperand(1, 16'd300, 16'hFF00);
    req[1] = 1'b1;
    fork
      applyStimulus(1, 16'd300, 16'hFF00, LATENCY + 1, 1'b1, 1'b1, a3);
      begin
        repeat (5) @(negedge clock);
        req[3] = 1'b1;
        @(negedge clock);
        req[3] = 1'b0;
      end
    join
    repeat (40) tick();
    checkOutput("pulse ack3", 64'(ack3Count - baseAck3), 64'd0);
    checkOutput("pulse res3", 64'(res3Count - base3), 64'd0);

    // Reset in WAIT with 5 cycles left: the result is discarded.
    base = resCount;
    req[2] = 1'b1;
    waitAck(got);
    checkOutput("reset-test ack", 64'(ack), 64'b0100);
    req[2] = 1'b0;
    repeat (12) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset ctrl", 64'({ack, cordic_start, res_valid, res_id, busy}), 64'd0);
    checkOutput("reset data", 64'({cordic_x, cordic_y, res_mod, res_angle}), 64'd0);
    tick();
    reset = 1'b1;
    repeat (25) tick();
    checkOutput("no stale result", 64'(resCount - base), 64'd0);
    checkOutput("res_mod after reset", 64'(res_mod), 64'd0);
    setOperand(1, 16'd4096, 16'd77);
    req[1] = 1'b1;
    applyStimulus(1, 16'd4096, 16'd77, LATENCY + 1, 1'b1, 1'b1, a0);

    // Zero operands on channel 1.
    tick();
    setOperand(1, 16'd0, 16'd0);
    req[1] = 1'b1;
`ifdef R2P_ZERO_BYPASS_EN
    applyStimulus(1, 16'd0, 16'd0, 1, 1'b0, 1'b1, a0);
`else
    applyStimulus(1, 16'd0, 16'd0, LATENCY + 1, 1'b1, 1'b1, a0);
`endif
    tick();
    checkOutput("res_valid pulse", 64'(res_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
